syscall_unit: RTL and testbench

//  Parametrised syscall controller for the single-cycle/pipelined CPU. Decodes the

---
 rtl/syscall_pkg.sv | 14 +
 rtl/syscall_fifo.sv | 65 ++++++
 rtl/syscall_unit.sv | 106 ++++++++++
 tb/tb_syscall_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall controller: default service codes and the
// controller state encoding.
package syscall_pkg;

    localparam int unsigned SVC_HALT_DEF  = 10;
    localparam int unsigned SVC_PAUSE_DEF = 50;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_HALTED = 2'd2
    } sys_state_e;

endpackage : syscall_pkg

// File: rtl/syscall_fifo.sv
// Synchronous print FIFO; occupancy count one bit wider than the pointers
// distinguishes full from empty.
module syscall_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] pushData,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] popData,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign popData = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when a pop frees the head slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the cleared count makes stale entries unreachable.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= pushData;
    end

endmodule : syscall_fifo

// File: rtl/syscall_unit.sv
// Syscall controller: decodes halt/pause/print services, gates the CPU enable,
// buffers print values and counts accepted syscalls.
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned SVC_HALT   = SVC_HALT_DEF,
    parameter int unsigned SVC_PAUSE  = SVC_PAUSE_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  syscall,
    input  logic [DATA_WIDTH-1:0] regSValue,
    input  logic [DATA_WIDTH-1:0] regTValue,
    input  logic                  resume,
    input  logic                  outReady,
    output logic                  enable,
    output logic                  halted,
    output logic                  outValid,
    output logic [DATA_WIDTH-1:0] outData,
    output logic [DATA_WIDTH-1:0] syscallOutput,
    output logic [CNT_WIDTH-1:0]  syscallCount
);

    sys_state_e            state_q, state_d;
    logic                  halted_q, halted_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic is_halt, is_pause, is_print;
    logic in_run, accept, take;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign is_halt  = (regSValue == DATA_WIDTH'(SVC_HALT));
    assign is_pause = (regSValue == DATA_WIDTH'(SVC_PAUSE));
    assign is_print = !is_halt && !is_pause;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (syscall && is_halt)       state_d = ST_HALTED;
                else if (syscall && is_pause) state_d = ST_PAUSED;
            end
            ST_PAUSED: if (resume) state_d = ST_RUN;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // A stalled print keeps enable low so the same instruction is re-presented.
    always_comb begin
        in_run    = (state_q == ST_RUN);
        fifo_pop  = !fifo_empty && outReady;
        accept    = !fifo_full || fifo_pop;
        fifo_push = in_run && syscall && is_print && accept;
        take      = in_run && syscall && (is_halt || is_pause || fifo_push);
        enable    = in_run && !(syscall && is_print && !accept);
    end

    always_comb begin
        halted_d = (state_d == ST_HALTED);
        out_d    = fifo_push ? regTValue : out_q;
        cnt_d    = cnt_q;
        if (take && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halted_q <= 1'b0;
            out_q    <= '0;
            cnt_q    <= '0;
        end else begin
            halted_q <= halted_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
        end
    end

    syscall_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .pushData (regTValue),
        .pop      (fifo_pop),
        .popData  (outData),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign halted        = halted_q;
    assign outValid      = !fifo_empty;
    assign syscallOutput = out_q;
    assign syscallCount  = cnt_q;

endmodule : syscall_unit

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_syscall_unit;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          syscall = 1'b0;
    logic [DW-1:0] regSValue = '0;
    logic [DW-1:0] regTValue = '0;
    logic          resume = 1'b0;
    logic          outReady = 1'b0;
    logic          enable, halted, outValid;
    logic [DW-1:0] outData, syscallOutput;
    logic [CW-1:0] syscallCount;

    int total = 0;
    int bad   = 0;

    // Behavioural model
    logic [DW-1:0] mq[$];
    bit            m_paused, m_halted;
    logic [DW-1:0] m_out;
    int            m_cnt;

    syscall_unit #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW),
        .SVC_HALT   (10),
        .SVC_PAUSE  (50)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .syscall       (syscall),
        .regSValue     (regSValue),
        .regTValue     (regTValue),
        .resume        (resume),
        .outReady      (outReady),
        .enable        (enable),
        .halted        (halted),
        .outValid      (outValid),
        .outData       (outData),
        .syscallOutput (syscallOutput),
        .syscallCount  (syscallCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_paused = 0;
        m_halted = 0;
        m_out    = '0;
        m_cnt    = 0;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input logic sc, input logic [DW-1:0] s, input logic [DW-1:0] t,
                        input logic rs, input logic rdy);
        bit is_print, pop, acc, run, exp_en;
        int sz;
        @(negedge clock);
        syscall = sc; regSValue = s; regTValue = t; resume = rs; outReady = rdy;
        #1;
        sz       = mq.size();
        run      = !m_paused && !m_halted;
        is_print = (s != 10) && (s != 50);
        pop      = (sz > 0) && rdy;
        acc      = (sz < DEPTH) || pop;
        exp_en   = run && !(sc && is_print && !acc);
        check("enable", {31'd0, enable}, {31'd0, exp_en});
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        check("outValid", {31'd0, outValid}, {31'd0, sz > 0});
        if (sz > 0) check("outData", outData, mq[0]);
        check("syscallOutput", syscallOutput, m_out);
        check("syscallCount", DW'(syscallCount), DW'(m_cnt));
        @(posedge clock);
        if (pop) void'(mq.pop_front());
        if (run && sc) begin
            if (s == 10) begin
                m_halted = 1;
                m_cnt = (m_cnt == 2**CW - 1) ? m_cnt : m_cnt + 1;
            end else if (s == 50) begin
                m_paused = 1;
                m_cnt = (m_cnt == 2**CW - 1) ? m_cnt : m_cnt + 1;
            end else if (acc) begin
                mq.push_back(t);
                m_out = t;
                m_cnt = (m_cnt == 2**CW - 1) ? m_cnt : m_cnt + 1;
            end
        end else if (m_paused && rs) begin
            m_paused = 0;
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, rdy);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        @(negedge clock);
        syscall = 0; resume = 0; outReady = 0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("rst_outValid", {31'd0, outValid}, 32'd0);
        check("rst_syscallOutput", syscallOutput, 32'd0);
        check("rst_count", DW'(syscallCount), 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_enable", {31'd0, enable}, 32'd1);
    endtask

    initial begin
        logic [DW-1:0] s;
        model_reset();
        #12 reset = 1'b1;
        idle(1, 1'b0);

        // 1: single print
        step(1'b1, 32'd1, 32'h1234, 1'b0, 1'b0);
        #2;
        check("t1_syscallOutput", syscallOutput, 32'h1234);
        check("t1_outData", outData, 32'h1234);
        check("t1_count", DW'(syscallCount), 32'd1);
        idle(1, 1'b1);

        // 2: overfill by one, then a single pop lets the stalled print in
        for (int i = 1; i <= 9; i++) step(1'b1, 32'd1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 32'd1, 32'd9, 1'b0, 1'b1);
        idle(10, 1'b1);

        // 3: pause, ignored syscall, resume
        step(1'b1, 32'd50, '0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 32'd1, 32'hdead, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        idle(1, 1'b0);

        // 5: full FIFO with a simultaneous pop and print
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'd2, 32'h100 + DW'(i), 1'b0, 1'b0);
        step(1'b1, 32'd2, 32'h1ff, 1'b0, 1'b1);
        #2;
        check("t5_full_kept", DW'(mq.size()), DW'(DEPTH));
        check("t5_head", outData, 32'h101);

        // 4: halt with pending entries; resume and print ignored; FIFO drains
        step(1'b1, 32'd10, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 32'd3, 32'h77, 1'b0, 1'b1);
        idle(DEPTH, 1'b1);
        #2;
        check("t4_halted", {31'd0, halted}, 32'd1);

        // 6: reset while paused with three queued entries
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'd4, 32'h40 + DW'(i), 1'b0, 1'b0);
        step(1'b1, 32'd50, '0, 1'b0, 1'b0);
        idle(1, 1'b0);
        pulse_reset();
        idle(1, 1'b0);

        // Full-width compare: near-miss service numbers are prints
        step(1'b1, 32'h0001_000a, 32'haaaa, 1'b0, 1'b1);
        step(1'b1, 32'h8000_0032, 32'hbbbb, 1'b0, 1'b1);

        // Counter saturation
        for (int i = 0; i < 20; i++) step(1'b1, 32'd5, DW'(i), 1'b0, 1'b1);

        // Random traffic with periodic resets
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) pulse_reset();
            case ($urandom_range(0, 9))
                0:       s = 32'd10;
                1, 2:    s = 32'd50;
                3:       s = 32'd10 | (32'd1 << $urandom_range(4, 31));
                default: s = DW'($urandom_range(0, 100));
            endcase
            step(($urandom_range(0, 9) < 5), s, DW'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
        end
        idle(2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_syscall_unit
